// File: rtl/scgra_run_ctrl_if.sv
// Control bundle between the host-side run registers and the SCGRA run sequencer.
// With RUN_PERF_CNT_EN defined the bundle also carries the Run_Cycles counter.
interface scgra_run_ctrl_if #(
    parameter int INST_AWIDTH = 10,
    parameter int ITER_WIDTH  = 16
);
    logic                   Start;
    logic [INST_AWIDTH-1:0] Inst_Cnt;
    logic [ITER_WIDTH-1:0]  Iter_Cnt;
    logic                   Abort;
    logic [INST_AWIDTH-1:0] Inst_Addr;
    logic                   Inst_Rd_En;
    logic                   PE_Array_Busy;
    logic                   Done;
    logic                   Aborted;
`ifdef RUN_PERF_CNT_EN
    logic [31:0]            Run_Cycles;
`endif

    modport master (
        output Start, Inst_Cnt, Iter_Cnt, Abort,
`ifdef RUN_PERF_CNT_EN
        input  Run_Cycles,
`endif
        input  Inst_Addr, Inst_Rd_En, PE_Array_Busy, Done, Aborted
    );

    modport slave (
        input  Start, Inst_Cnt, Iter_Cnt, Abort,
`ifdef RUN_PERF_CNT_EN
        output Run_Cycles,
`endif
        output Inst_Addr, Inst_Rd_En, PE_Array_Busy, Done, Aborted
    );
endinterface

// File: rtl/scgra_run_ctrl.sv
// Run-time sequencer for the 2x2 SCGRA PE array: broadcasts instruction addresses,
// drains the pipeline and pulses Done. Optional macro RUN_PERF_CNT_EN adds Run_Cycles.
module scgra_run_ctrl #(
    parameter int INST_AWIDTH  = 10,
    parameter int ITER_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 6   // legal range 1..15
) (
    input  logic              Clk,
    input  logic              Resetn,
    scgra_run_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [INST_AWIDTH-1:0] inst_cnt_q, inst_cnt_d;
    logic [INST_AWIDTH-1:0] addr_q, addr_d;
    logic [ITER_WIDTH-1:0]  iter_last_q, iter_last_d;
    logic [ITER_WIDTH-1:0]  iter_q, iter_d;
    logic [3:0]             drain_q, drain_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   rd_en_q, rd_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic                   run_start;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        inst_cnt_d   = inst_cnt_q;
        iter_last_d  = iter_last_q;
        addr_d       = addr_q;
        iter_d       = iter_q;
        drain_d      = drain_q;
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        rd_en_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        run_start    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    run_start    = 1'b1;
                    inst_cnt_d   = bus.Inst_Cnt;
                    // A zero iteration count runs once; storing count-1 keeps the compare overflow-free.
                    iter_last_d  = (bus.Iter_Cnt == '0) ? '0 : bus.Iter_Cnt - ITER_WIDTH'(1);
                    addr_d       = '0;
                    iter_d       = '0;
                    drain_d      = '0;
                    abort_pend_d = 1'b0;
                    aborted_d    = 1'b0;
                    if (bus.Inst_Cnt == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        rd_en_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (bus.Abort) begin
                    state_d      = DRAIN;
                    drain_d      = '0;
                    abort_pend_d = 1'b1;
                end else if (addr_q == inst_cnt_q - INST_AWIDTH'(1)) begin
                    if (iter_q == iter_last_q) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        addr_d  = '0;
                        iter_d  = iter_q + ITER_WIDTH'(1);
                        rd_en_d = 1'b1;
                    end
                end else begin
                    addr_d  = addr_q + INST_AWIDTH'(1);
                    rd_en_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    addr_d    = '0;
                    aborted_d = abort_pend_q;
                end else begin
                    drain_d = drain_q + 4'd1;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            inst_cnt_q   <= '0;
            iter_last_q  <= '0;
            addr_q       <= '0;
            iter_q       <= '0;
            drain_q      <= '0;
            abort_pend_q <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_cnt_q   <= inst_cnt_d;
            iter_last_q  <= iter_last_d;
            addr_q       <= addr_d;
            iter_q       <= iter_d;
            drain_q      <= drain_d;
            abort_pend_q <= abort_pend_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign bus.Inst_Addr     = addr_q;
    assign bus.Inst_Rd_En    = rd_en_q;
    assign bus.PE_Array_Busy = busy_q;
    assign bus.Done          = done_q;
    assign bus.Aborted       = aborted_q;

`ifdef RUN_PERF_CNT_EN
    logic [31:0] run_cycles_q;

    // Counts cycles with the registered busy flag high, so the total matches what the host observes.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            run_cycles_q <= '0;
        end else if (run_start) begin
            run_cycles_q <= '0;
        end else if (busy_q && (run_cycles_q != '1)) begin
            run_cycles_q <= run_cycles_q + 32'd1;
        end
    end

    assign bus.Run_Cycles = run_cycles_q;
`endif
endmodule

// File: tb/tb_scgra_run_ctrl.sv
// Self-checking bench for scgra_run_ctrl: a run-level timing model checked every cycle,
// plus directed runs with hand-computed expectations.
module tb_scgra_run_ctrl;
    localparam int INST_AWIDTH = 10;
    localparam int ITER_WIDTH  = 16;
    localparam int DRAIN       = 6;

    typedef struct {
        int addr;
        int rd;
        int busy;
        int done;
        int aborted;
        int cycles;
    } exp_t;

    logic Clk    = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clk = ~Clk;

    scgra_run_ctrl_if #(.INST_AWIDTH(INST_AWIDTH), .ITER_WIDTH(ITER_WIDTH)) bus ();

    scgra_run_ctrl #(
        .INST_AWIDTH (INST_AWIDTH),
        .ITER_WIDTH  (ITER_WIDTH),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .Clk   (Clk),
        .Resetn(Resetn),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Run-level model: one record per accepted Start, outputs derived from cycle offsets.
    bit m_active = 1'b0;
    bit m_abort  = 1'b0;
    int m_t0     = 0;
    int m_n      = 0;
    int m_reads  = 0;
    int m_deff   = 0;
    int m_done   = 0;

    function automatic int eff_iter(input int it);
        return (it == 0) ? 1 : it;
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            m_active <= 1'b0;
            m_abort  <= 1'b0;
        end else if (bus.Start && (!m_active || cyc > m_done)) begin
            m_active <= 1'b1;
            m_abort  <= 1'b0;
            m_t0     <= cyc;
            m_n      <= int'(bus.Inst_Cnt);
            m_reads  <= int'(bus.Inst_Cnt) * eff_iter(int'(bus.Iter_Cnt));
            m_deff   <= (bus.Inst_Cnt != '0) ? DRAIN : 0;
            m_done   <= cyc + 1 + int'(bus.Inst_Cnt) * eff_iter(int'(bus.Iter_Cnt))
                        + ((bus.Inst_Cnt != '0) ? DRAIN : 0);
        end else if (bus.Abort && m_active && cyc >= m_t0 + 1 && cyc <= m_t0 + m_reads) begin
            m_abort  <= 1'b1;
            m_reads  <= cyc - m_t0;
            m_done   <= cyc + 1 + DRAIN;
        end
    end

    function automatic exp_t model_at(input int c);
        exp_t e;
        e = '{default: 0};
        if (m_active) begin
            e.rd   = (c >= m_t0 + 1 && c <= m_t0 + m_reads) ? 1 : 0;
            e.busy = (c >= m_t0 + 1 && c <= m_t0 + m_reads + m_deff) ? 1 : 0;
            e.done = (c == m_done) ? 1 : 0;
            if (e.rd == 1)
                e.addr = (c - m_t0 - 1) % m_n;
            else if (c > m_t0 + m_reads && c < m_done && m_n > 0)
                e.addr = (m_reads - 1) % m_n;
            e.aborted = (m_abort && c >= m_done) ? 1 : 0;
            e.cycles  = (c - 1 - m_t0 < 0) ? 0 :
                        (c - 1 - m_t0 > m_reads + m_deff) ? m_reads + m_deff : c - 1 - m_t0;
        end
        return e;
    endfunction

    always @(negedge Clk) begin
        exp_t e;
        e = model_at(cyc);
        check("addr",    int'(bus.Inst_Addr),     e.addr);
        check("rd_en",   int'(bus.Inst_Rd_En),    e.rd);
        check("busy",    int'(bus.PE_Array_Busy), e.busy);
        check("done",    int'(bus.Done),          e.done);
        check("aborted", int'(bus.Aborted),       e.aborted);
`ifdef RUN_PERF_CNT_EN
        check("run_cycles", int'(bus.Run_Cycles), e.cycles);
`endif
    end

    // Per-run observations, offsets relative to the Start cycle T.
    int cap_addr [16];
    int done_off, busy_n, rd_n, ab_first, ab_done;

    task automatic run_case(input int n, input int it, input int abort_k,
                            input bit repulse, input bit abort_with_start);
        @(negedge Clk);
        bus.Start    = 1'b1;
        bus.Abort    = abort_with_start;
        bus.Inst_Cnt = INST_AWIDTH'(n);
        bus.Iter_Cnt = ITER_WIDTH'(it);
        done_off = -1; busy_n = 0; rd_n = 0; ab_first = -1; ab_done = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (bus.PE_Array_Busy) busy_n++;
            if (bus.Inst_Rd_En) begin
                if (rd_n < 16) cap_addr[rd_n] = int'(bus.Inst_Addr);
                rd_n++;
            end
            if (bus.Done && done_off < 0) begin
                done_off = k;
                ab_done  = int'(bus.Aborted);
            end
            if (k == 1) ab_first = int'(bus.Aborted);
            bus.Start = repulse && (k == 3 || k == 10);
            bus.Abort = (k == abort_k);
        end
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
    endtask

    task automatic check_baseline(input string tag);
        int exp_addr [8];
        exp_addr = '{0, 1, 2, 3, 0, 1, 2, 3};
        check({tag, "_done_at"}, done_off, 15);
        check({tag, "_busy_cycles"}, busy_n, 14);
        check({tag, "_reads"}, rd_n, 8);
        check({tag, "_aborted"}, ab_done, 0);
        for (int i = 0; i < 8; i++) check({tag, "_addr_seq"}, cap_addr[i], exp_addr[i]);
`ifdef RUN_PERF_CNT_EN
        check({tag, "_run_cycles"}, int'(bus.Run_Cycles), 14);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        bus.Start    = 1'b0;
        bus.Abort    = 1'b0;
        bus.Inst_Cnt = '0;
        bus.Iter_Cnt = '0;

        repeat (3) @(negedge Clk);
        check("reset_addr",  int'(bus.Inst_Addr),     0);
        check("reset_busy",  int'(bus.PE_Array_Busy), 0);
        check("reset_done",  int'(bus.Done),          0);
        #2 Resetn = 1'b1;

        // Abort while idle must do nothing.
        @(negedge Clk); bus.Abort = 1'b1;
        repeat (3) @(negedge Clk);
        bus.Abort = 1'b0;

        run_case(4, 2, 0, 1'b0, 1'b0);
        check_baseline("base");

        run_case(0, 5, 0, 1'b0, 1'b0);
        check("zero_done_at", done_off, 1);
        check("zero_busy",    busy_n,   0);
        check("zero_reads",   rd_n,     0);

        run_case(3, 0, 0, 1'b0, 1'b0);
        check("iter0_done_at", done_off, 10);
        check("iter0_reads",   rd_n,     3);
        check("iter0_addr2",   cap_addr[2], 2);

        run_case(8, 3, 6, 1'b0, 1'b0);
        check("abort_reads",   rd_n,     6);
        check("abort_done_at", done_off, 13);
        check("abort_busy",    busy_n,   12);
        check("abort_flag",    ab_done,  1);

        // Start+Abort together in IDLE, then Start re-pulsed in RUN and DRAIN.
        run_case(4, 2, 0, 1'b1, 1'b1);
        check("restart_clears_aborted", ab_first, 0);
        check_baseline("repulse");

        @(negedge Clk);
        bus.Start    = 1'b1;
        bus.Inst_Cnt = INST_AWIDTH'(8);
        bus.Iter_Cnt = ITER_WIDTH'(3);
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge Clk);
        #2 Resetn = 1'b0;
        #1;
        check("midreset_addr",  int'(bus.Inst_Addr),     0);
        check("midreset_rd",    int'(bus.Inst_Rd_En),    0);
        check("midreset_busy",  int'(bus.PE_Array_Busy), 0);
        check("midreset_done",  int'(bus.Done),          0);
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (bus.Done) done_seen++;
        end
        #2 Resetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clk);
            if (bus.Done) done_seen++;
        end
        check("midreset_no_done", done_seen, 0);

        run_case(4, 2, 0, 1'b0, 1'b0);
        check_baseline("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
